fwd_hazard_unit: RTL and testbench

- Parametrised forwarding and load-use hazard unit for the 5-stage pipeline.
- Generates per-operand forwarding selects for EX-stage ALU source muxes. Supports N source operands and configurable register-address width.
- Contains a stall FSM that holds PC and IF/ID and injects bubbles into ID/EX for load-use hazards lasting LOAD_LAT cycles.
- Honours a global memory-stall freeze.

---
 rtl/fwd_hazard_unit.sv | 128 ++++++++++++
 tb/tb_fwd_hazard_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding select generation and load-use stall control for the 5-stage pipeline.
// Optional feature: define FW_WB_BYPASS_EN to add a post-writeback forwarding source
// (wb_wb_i / wb_rd_i, select code 11) for register files without write-through.
module fwd_hazard_unit #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      mem_stall_i,
    input  logic [NUM_SRC*REG_AW-1:0] id_src_i,
    input  logic [NUM_SRC-1:0]        id_src_vld_i,
    input  logic [NUM_SRC*REG_AW-1:0] ex_src_i,
    input  logic                      idex_memrd_i,
    input  logic [REG_AW-1:0]         idex_rd_i,
    input  logic                      exmem_wb_i,
    input  logic [REG_AW-1:0]         exmem_rd_i,
    input  logic                      memwb_wb_i,
    input  logic [REG_AW-1:0]         memwb_rd_i,
`ifdef FW_WB_BYPASS_EN
    input  logic                      wb_wb_i,
    input  logic [REG_AW-1:0]         wb_rd_i,
`endif
    output logic [2*NUM_SRC-1:0]      fwd_sel_o,
    output logic                      stall_o,
    output logic                      bubble_o,
    output logic                      busy_o
);

    typedef enum logic {StIdle, StStall} state_e;

    localparam logic [CNT_W-1:0] CntInit = CNT_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_SRC-1:0] id_hit;
    logic               hz;

    // Producers writing x0 are never valid forwarding sources.
    logic exmem_ok, memwb_ok;
    assign exmem_ok = exmem_wb_i && (exmem_rd_i != '0);
    assign memwb_ok = memwb_wb_i && (memwb_rd_i != '0);
`ifdef FW_WB_BYPASS_EN
    logic wb_ok;
    assign wb_ok = wb_wb_i && (wb_rd_i != '0);
`endif

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        logic [REG_AW-1:0] ex_src;
        logic [REG_AW-1:0] id_src;
        logic [1:0]        sel;

        assign ex_src = ex_src_i[k*REG_AW +: REG_AW];
        assign id_src = id_src_i[k*REG_AW +: REG_AW];

        // Per-operand select, youngest producer first.
        always_comb begin
            sel = 2'b00;
            if (exmem_ok && (exmem_rd_i == ex_src)) begin
                sel = 2'b10;
            end else if (memwb_ok && (memwb_rd_i == ex_src)) begin
                sel = 2'b01;
`ifdef FW_WB_BYPASS_EN
            end else if (wb_ok && (wb_rd_i == ex_src)) begin
                sel = 2'b11;
`endif
            end
        end

        assign fwd_sel_o[2*k +: 2] = sel;
        assign id_hit[k]           = id_src_vld_i[k] && (id_src == idex_rd_i);
    end

    assign hz = idex_memrd_i && (idex_rd_i != '0) && (|id_hit);

    // Stall FSM next-state and outputs; hz only matters when idle and not frozen.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall_o  = 1'b0;
        bubble_o = 1'b0;
        busy_o   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mem_stall_i) begin
                    stall_o = 1'b1;
                end else if (hz) begin
                    stall_o  = 1'b1;
                    bubble_o = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_d = StStall;
                        cnt_d   = CntInit;
                    end
                end
            end
            StStall: begin
                stall_o = 1'b1;
                busy_o  = 1'b1;
                if (!mem_stall_i) begin
                    bubble_o = 1'b1;
                    cnt_d    = cnt_q - 1'b1;
                    if (cnt_q == CntLast) begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: one instance with LOAD_LAT=1 and one with LOAD_LAT=3 share stimulus.
module tb_fwd_hazard_unit;

    localparam int unsigned AW = 5;
    localparam int unsigned NS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             mem_stall;
    logic [NS*AW-1:0] id_src;
    logic [NS-1:0]    vld;
    logic [NS*AW-1:0] ex_src;
    logic             idex_memrd;
    logic [AW-1:0]    idex_rd;
    logic             exmem_wb;
    logic [AW-1:0]    exmem_rd;
    logic             memwb_wb;
    logic [AW-1:0]    memwb_rd;
`ifdef FW_WB_BYPASS_EN
    logic             wb_wb;
    logic [AW-1:0]    wb_rd;
`endif

    logic [3:0] fwd1, fwd3;
    logic       s1, b1, y1, s3, b3, y3;

    fwd_hazard_unit #(.REG_AW(AW), .NUM_SRC(NS), .LOAD_LAT(1), .CNT_W(4)) u_dut1 (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .mem_stall_i  (mem_stall),
        .id_src_i     (id_src),
        .id_src_vld_i (vld),
        .ex_src_i     (ex_src),
        .idex_memrd_i (idex_memrd),
        .idex_rd_i    (idex_rd),
        .exmem_wb_i   (exmem_wb),
        .exmem_rd_i   (exmem_rd),
        .memwb_wb_i   (memwb_wb),
        .memwb_rd_i   (memwb_rd),
`ifdef FW_WB_BYPASS_EN
        .wb_wb_i      (wb_wb),
        .wb_rd_i      (wb_rd),
`endif
        .fwd_sel_o    (fwd1),
        .stall_o      (s1),
        .bubble_o     (b1),
        .busy_o       (y1)
    );

    fwd_hazard_unit #(.REG_AW(AW), .NUM_SRC(NS), .LOAD_LAT(3), .CNT_W(4)) u_dut3 (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .mem_stall_i  (mem_stall),
        .id_src_i     (id_src),
        .id_src_vld_i (vld),
        .ex_src_i     (ex_src),
        .idex_memrd_i (idex_memrd),
        .idex_rd_i    (idex_rd),
        .exmem_wb_i   (exmem_wb),
        .exmem_rd_i   (exmem_rd),
        .memwb_wb_i   (memwb_wb),
        .memwb_rd_i   (memwb_rd),
`ifdef FW_WB_BYPASS_EN
        .wb_wb_i      (wb_wb),
        .wb_rd_i      (wb_rd),
`endif
        .fwd_sel_o    (fwd3),
        .stall_o      (s3),
        .bubble_o     (b3),
        .busy_o       (y3)
    );

    typedef struct packed {
        logic       dut3;
        logic [3:0] fwd;
        logic       stall;
        logic       bubble;
        logic       busy;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic push(input string tag, input logic dut3, input logic [3:0] f,
                        input logic s, input logic b, input logic y);
        exp_t e;
        e.dut3   = dut3;
        e.fwd    = f;
        e.stall  = s;
        e.bubble = b;
        e.busy   = y;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        mem_stall  = 1'b0;
        id_src     = '0;
        vld        = '0;
        ex_src     = '0;
        idex_memrd = 1'b0;
        idex_rd    = '0;
        exmem_wb   = 1'b0;
        exmem_rd   = '0;
        memwb_wb   = 1'b0;
        memwb_rd   = '0;
`ifdef FW_WB_BYPASS_EN
        wb_wb      = 1'b0;
        wb_rd      = '0;
`endif
    endtask

    function automatic logic [NS*AW-1:0] pack2(input int a1, input int a0);
        return {AW'(a1), AW'(a0)};
    endfunction

    // Load rd=5 consumed by operand 1 of the instruction in ID.
    task automatic set_hz(input logic [NS-1:0] v);
        idex_memrd = 1'b1;
        idex_rd    = 5'd5;
        id_src     = pack2(5, 2);
        vld        = v;
    endtask

    // Scoreboard consumer: outputs are compared midway between rising edges.
    exp_t        m_e;
    string       m_t;
    logic [3:0]  m_f;
    logic        m_s, m_b, m_y;
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            m_e = sb_q.pop_front();
            m_t = tag_q.pop_front();
            m_f = m_e.dut3 ? fwd3 : fwd1;
            m_s = m_e.dut3 ? s3 : s1;
            m_b = m_e.dut3 ? b3 : b1;
            m_y = m_e.dut3 ? y3 : y1;
            check_eq({m_t, ".fwd"}, 32'(m_f), 32'(m_e.fwd));
            check_eq({m_t, ".stall"}, 32'(m_s), 32'(m_e.stall));
            check_eq({m_t, ".bubble"}, 32'(m_b), 32'(m_e.bubble));
            check_eq({m_t, ".busy"}, 32'(m_y), 32'(m_e.busy));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        clr();
        rst_n = 1'b0;
        #2;
        check_eq("rst.stall1", 32'(s1), 0);
        check_eq("rst.stall3", 32'(s3), 0);
        check_eq("rst.busy3", 32'(y3), 0);
        check_eq("rst.fwd1", 32'(fwd1), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Forwarding: youngest wins, then MEM/WB, x0 and disabled writers never forward.
        ex_src = pack2(9, 3); exmem_wb = 1'b1; exmem_rd = 5'd3; memwb_wb = 1'b1; memwb_rd = 5'd3;
        push("fwd_young", 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0);
        tick();
        exmem_wb = 1'b0;
        push("fwd_memwb", 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0);
        tick();
        memwb_wb = 1'b0;
        push("fwd_nowb", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();
        clr(); exmem_wb = 1'b1; memwb_wb = 1'b1;
        push("fwd_x0", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();
        ex_src = pack2(4, 6); exmem_rd = 5'd6; memwb_rd = 5'd4;
        push("fwd_split", 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0);
        tick();

        // Load into x0 never stalls.
        clr(); idex_memrd = 1'b1; vld = 2'b11;
        push("hz_x0_1", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        push("hz_x0_3", 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();

        // Load-use: LOAD_LAT=1 stalls once, LOAD_LAT=3 stalls three cycles.
        clr(); set_hz(2'b10);
        push("lu_c0_1", 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
        push("lu_c0_3", 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0);
        tick();
        clr();
        push("lu_c1_1", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        push("lu_c1_3", 1'b1, 4'b0000, 1'b1, 1'b1, 1'b1);
        tick();
        push("lu_c2_3", 1'b1, 4'b0000, 1'b1, 1'b1, 1'b1);
        tick();
        push("lu_c3_3", 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();

        // Operand not actually read: no hazard.
        set_hz(2'b01);
        push("novld_1", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        push("novld_3", 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();

        // Memory freeze in the second stall cycle stretches LOAD_LAT=3 to four cycles.
        clr(); set_hz(2'b10);
        push("ms_c0_1", 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
        push("ms_c0_3", 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0);
        tick();
        clr(); mem_stall = 1'b1;
        push("ms_c1_1", 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        push("ms_c1_3", 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1);
        tick();
        mem_stall = 1'b0;
        push("ms_c2_1", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        push("ms_c2_3", 1'b1, 4'b0000, 1'b1, 1'b1, 1'b1);
        tick();
        push("ms_c3_3", 1'b1, 4'b0000, 1'b1, 1'b1, 1'b1);
        tick();
        push("ms_c4_3", 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();

        // Freeze while idle masks a hazard.
        set_hz(2'b10); mem_stall = 1'b1;
        push("ms_idle_3", 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
        tick();
        clr();
        push("ms_idle_after3", 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();

        // Asynchronous reset in the middle of a stall.
        set_hz(2'b10);
        push("ar_c0_3", 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0);
        tick();
        clr();
        push("ar_c1_3", 1'b1, 4'b0000, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_stall3", 32'(s3), 0);
        check_eq("ar_busy3", 32'(y3), 0);
        check_eq("ar_bubble3", 32'(b3), 0);
        #4;
        rst_n = 1'b1;
        push("ar_post0_3", 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();
        push("ar_post1_3", 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();

`ifdef FW_WB_BYPASS_EN
        // Post-writeback source only when nothing younger matches.
        clr(); ex_src = pack2(7, 1); wb_wb = 1'b1; wb_rd = 5'd7;
        push("wbb_only", 1'b0, 4'b1100, 1'b0, 1'b0, 1'b0);
        tick();
        memwb_wb = 1'b1; memwb_rd = 5'd7;
        push("wbb_memwb", 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0);
        tick();
`endif

        @(negedge clk);
        #1;
        check_eq("sb_drain", 32'(sb_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
